// File: rtl/npc_pkg.sv
// Shared fetch-path definitions: widths, default reset PC and the prefetch entry layout.
package npc_pkg;

   localparam int unsigned     XLEN             = 64;
   localparam int unsigned     ILEN             = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h8000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] inst;
      logic            filled;
   } fetch_entry_t;

endpackage

// File: rtl/ifu_pf_queue.sv
// In-order prefetch ring: entries are allocated at request time, filled by responses
// in request order and popped by decode. Pointers carry an extra wrap bit.
module ifu_pf_queue #(
   parameter int unsigned  XLEN  = 64,
   parameter int unsigned  DEPTH = 4,
   localparam int unsigned PW    = $clog2(DEPTH) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     alloc,
   input  logic [XLEN-1:0]          alloc_pc,
   input  logic                     fill,
   input  logic [npc_pkg::ILEN-1:0] fill_inst,
   input  logic                     pop,
   output logic [PW-1:0]            count,
   output logic [PW-1:0]            outstanding,
   output logic                     head_valid,
   output logic [npc_pkg::ILEN-1:0] head_inst,
   output logic [XLEN-1:0]          head_pc
);

   import npc_pkg::*;

   localparam int unsigned IW = PW - 1;

   fetch_entry_t  ring_q [DEPTH];
   fetch_entry_t  ring_d [DEPTH];
   logic [PW-1:0] alloc_ptr_q, alloc_ptr_d;
   logic [PW-1:0] fill_ptr_q, fill_ptr_d;
   logic [PW-1:0] head_ptr_q, head_ptr_d;
   logic [IW-1:0] alloc_idx, fill_idx, head_idx;

   assign alloc_idx   = alloc_ptr_q[IW-1:0];
   assign fill_idx    = fill_ptr_q[IW-1:0];
   assign head_idx    = head_ptr_q[IW-1:0];
   assign count       = alloc_ptr_q - head_ptr_q;
   assign outstanding = alloc_ptr_q - fill_ptr_q;

   assign head_valid = ring_q[head_idx].filled && (count != '0);
   assign head_inst  = ring_q[head_idx].inst;
   assign head_pc    = ring_q[head_idx].pc;

   // Alloc never targets the fill or head slot: that would need count == DEPTH,
   // in which case no request can be accepted.
   always_comb begin
      ring_d      = ring_q;
      alloc_ptr_d = alloc_ptr_q;
      fill_ptr_d  = fill_ptr_q;
      head_ptr_d  = head_ptr_q;
      if (flush) begin
         alloc_ptr_d = '0;
         fill_ptr_d  = '0;
         head_ptr_d  = '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            ring_d[i].filled = 1'b0;
         end
      end else begin
         if (alloc) begin
            ring_d[alloc_idx].pc     = alloc_pc;
            ring_d[alloc_idx].filled = 1'b0;
            alloc_ptr_d              = alloc_ptr_q + 1'b1;
         end
         if (fill) begin
            ring_d[fill_idx].inst   = fill_inst;
            ring_d[fill_idx].filled = 1'b1;
            fill_ptr_d              = fill_ptr_q + 1'b1;
         end
         if (pop) begin
            head_ptr_d = head_ptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alloc_ptr_q <= '0;
         fill_ptr_q  <= '0;
         head_ptr_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            ring_q[i] <= '0;
         end
      end else begin
         alloc_ptr_q <= alloc_ptr_d;
         fill_ptr_q  <= fill_ptr_d;
         head_ptr_q  <= head_ptr_d;
         ring_q      <= ring_d;
      end
   end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction-fetch front end: sequential prefetch into an in-order queue, with redirect
// flushing the queue and discarding responses still in flight.
module ifu_prefetch #(
   parameter int unsigned     XLEN     = npc_pkg::XLEN,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = npc_pkg::RESET_PC_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     redirect_valid,
   input  logic [XLEN-1:0]          redirect_pc,
   output logic                     imem_req_valid,
   input  logic                     imem_req_ready,
   output logic [XLEN-1:0]          imem_req_addr,
   input  logic                     imem_resp_valid,
   input  logic [npc_pkg::ILEN-1:0] imem_resp_data,
   output logic                     inst_valid,
   input  logic                     inst_ready,
   output logic [npc_pkg::ILEN-1:0] inst,
   output logic [XLEN-1:0]          inst_pc
);

   import npc_pkg::*;

   localparam int unsigned PW      = $clog2(DEPTH) + 1;
   localparam logic [PW:0] DEPTH_W = DEPTH[PW:0];

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [PW-1:0]   drop_cnt_q, drop_cnt_d;
   logic [PW-1:0]   count, outstanding;
   logic [PW:0]     occupancy;
   logic            req_hs, resp_fill, deliver;
   logic [ILEN-1:0] head_inst;

   // Slots still owed to the memory for discarded responses count as occupied.
   assign occupancy      = {1'b0, count} + {1'b0, drop_cnt_q};
   assign imem_req_valid = !rst && (occupancy < DEPTH_W);
   assign imem_req_addr  = fetch_pc_q;
   assign req_hs         = imem_req_valid && imem_req_ready;
   assign resp_fill      = imem_resp_valid && (drop_cnt_q == '0);
   assign deliver        = inst_valid && inst_ready;
   assign inst           = head_inst;

   ifu_pf_queue #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk         (clk),
      .rst         (rst),
      .flush       (redirect_valid),
      .alloc       (req_hs),
      .alloc_pc    (fetch_pc_q),
      .fill        (resp_fill),
      .fill_inst   (imem_resp_data),
      .pop         (deliver),
      .count       (count),
      .outstanding (outstanding),
      .head_valid  (inst_valid),
      .head_inst   (head_inst),
      .head_pc     (inst_pc)
   );

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      drop_cnt_d = drop_cnt_q;
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
         // Everything still owed by memory after this cycle becomes a discard.
         drop_cnt_d = outstanding + drop_cnt_q + {{(PW-1){1'b0}}, req_hs}
                      - {{(PW-1){1'b0}}, imem_resp_valid};
      end else begin
         if (req_hs) begin
            fetch_pc_d = fetch_pc_q + {{(XLEN-3){1'b0}}, 3'd4};
         end
         if (imem_resp_valid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         drop_cnt_q <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   resp_has_owner: assert property (@(posedge clk) disable iff (rst)
      imem_resp_valid |-> ((outstanding != '0) || (drop_cnt_q != '0)));

endmodule
